// File: rtl/srl_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// srl_fifo_ctrl
//
// 16-deep synchronous FIFO built on addressable shift-register storage.
// A push shifts every entry one slot deeper and loads the new word at tap 0.
// The oldest entry always sits at tap COUNT-1, so the read side is a mux
// indexed by the registered occupancy. The block owns all sequencing:
// shift enable, tap address, occupancy, and the valid/ready handshakes.
//
// Ports:
//   CLK          in   1      clock, rising edge
//   RST          in   1      asynchronous active-high reset
//   CLEAR        in   1      synchronous flush (beats push and pop)
//   S_DATA       in   WIDTH  write data
//   S_VALID      in   1      write request
//   S_READY      out  1      FIFO accepts a write this cycle (registered)
//   M_DATA       out  WIDTH  oldest entry, 0 when M_VALID=0
//   M_VALID      out  1      FIFO holds at least one entry (registered)
//   M_READY      in   1      consumer takes M_DATA this cycle
//   COUNT        out  5      occupancy 0..16 (registered)
//   ALMOST_FULL  out  1      COUNT >= AF_LEVEL (registered)
// -----------------------------------------------------------------------------
module srl_fifo_ctrl #(
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLEAR,
  input  logic [WIDTH-1:0] S_DATA,
  input  logic             S_VALID,
  output logic             S_READY,
  output logic [WIDTH-1:0] M_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [4:0]       COUNT,
  output logic             ALMOST_FULL
);

  localparam int DEPTH = 16;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

  state_t           r_state;
  logic [4:0]       r_count;
  logic             r_s_ready;
  logic             r_m_valid;
  logic             r_af;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_push;
  logic             w_pop;
  logic             w_shift;
  logic [4:0]       w_count_nxt;
  logic [4:0]       w_count_m1;
  logic [3:0]       w_tap;

  // Handshakes are qualified by the registered flags, so a write while
  // full or a read while empty simply never happens.
  assign w_push  = S_VALID & r_s_ready;
  assign w_pop   = r_m_valid & M_READY;
  // CLEAR wins: a push in the same cycle is dropped and nothing shifts.
  assign w_shift = w_push & ~CLEAR;

  // NOTE: every signal assigned in always_comb gets a default first, so a
  // missing branch can never infer a latch.
  always_comb begin
    w_count_nxt = r_count;
    if (CLEAR) begin
      w_count_nxt = 5'd0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + 5'd1;
        2'b01:   w_count_nxt = r_count - 5'd1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Control FSM: all outputs are registered alongside the state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_EMPTY;
      r_count   <= 5'd0;
      r_s_ready <= 1'b0;  // held low until the first edge after release
      r_m_valid <= 1'b0;
      r_af      <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_af      <= (w_count_nxt >= 5'(AF_LEVEL));
      if (CLEAR) begin
        r_state   <= ST_EMPTY;
        r_s_ready <= 1'b1;
        r_m_valid <= 1'b0;
      end else begin
        unique case (r_state)
          ST_EMPTY: begin
            r_s_ready <= 1'b1;
            if (w_push) begin
              r_state   <= ST_ACTIVE;
              r_m_valid <= 1'b1;
            end
          end
          ST_ACTIVE: begin
            if (w_push && !w_pop && r_count == 5'd15) begin
              r_state   <= ST_FULL;
              r_s_ready <= 1'b0;
            end else if (w_pop && !w_push && r_count == 5'd1) begin
              r_state   <= ST_EMPTY;
              r_m_valid <= 1'b0;
            end
          end
          ST_FULL: begin
            // No write pass-through: S_READY stays low until a pop lands.
            if (w_pop) begin
              r_state   <= ST_ACTIVE;
              r_s_ready <= 1'b1;
            end
          end
          default: begin
            r_state   <= ST_EMPTY;
            r_count   <= 5'd0;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  // NOTE: the shift storage has no reset; its contents are only ever
  // exposed through a tap below COUNT, which reset forces to zero.
  always_ff @(posedge CLK) begin
    if (w_shift) begin
      r_mem[0] <= S_DATA;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  // Oldest entry lives at COUNT-1. A simultaneous push and pop leaves the
  // tap unchanged while the shift brings the next-oldest entry under it.
  assign w_count_m1 = r_count - 5'd1;
  assign w_tap      = w_count_m1[3:0];

  assign M_DATA      = r_m_valid ? r_mem[w_tap] : '0;
  assign S_READY     = r_s_ready;
  assign M_VALID     = r_m_valid;
  assign COUNT       = r_count;
  assign ALMOST_FULL = r_af;

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_srl_fifo_ctrl
//
// Directed bench for srl_fifo_ctrl: fill to full with overflow attempt,
// ordered drain, streaming push+pop, empty-pop, CLEAR with coincident push,
// and an asynchronous reset pulse mid-cycle. Expected values are constants
// written out from the behaviour the FIFO must show.
// -----------------------------------------------------------------------------
module tb_srl_fifo_ctrl;

  logic       CLK;
  logic       RST;
  logic       CLEAR;
  logic [7:0] S_DATA;
  logic       S_VALID;
  logic       S_READY;
  logic [7:0] M_DATA;
  logic       M_VALID;
  logic       M_READY;
  logic [4:0] COUNT;
  logic       ALMOST_FULL;

  int total = 0;
  int bad   = 0;

  srl_fifo_ctrl #(.WIDTH(8), .AF_LEVEL(12)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .CLEAR       (CLEAR),
    .S_DATA      (S_DATA),
    .S_VALID     (S_VALID),
    .S_READY     (S_READY),
    .M_DATA      (M_DATA),
    .M_VALID     (M_VALID),
    .M_READY     (M_READY),
    .COUNT       (COUNT),
    .ALMOST_FULL (ALMOST_FULL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      $error("%s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST     = 1'b1;
    CLEAR   = 1'b0;
    S_DATA  = 8'h00;
    S_VALID = 1'b0;
    M_READY = 1'b0;

    // ---- reset state ----
    #12;
    check("rst_count", COUNT, 0);
    check("rst_mvalid", M_VALID, 0);
    check("rst_sready", S_READY, 0);
    check("rst_mdata", M_DATA, 0);
    check("rst_af", ALMOST_FULL, 0);
    RST = 1'b0;
    #1;
    check("rel_sready_low", S_READY, 0);
    tick();
    check("rel_sready_high", S_READY, 1);
    check("rel_count", COUNT, 0);

    // ---- fill 0x01..0x10 with no reads ----
    for (int i = 1; i <= 16; i++) begin
      S_VALID = 1'b1;
      S_DATA  = 8'(i);
      tick();
      check("fill_count", COUNT, 32'(i));
      check("fill_af", ALMOST_FULL, (i >= 12) ? 1 : 0);
      check("fill_mvalid", M_VALID, 1);
      check("fill_oldest", M_DATA, 8'h01);
      check("fill_sready", S_READY, (i < 16) ? 1 : 0);
    end

    // ---- overflow attempt ----
    S_DATA = 8'hAA;
    tick();
    check("ovf_count", COUNT, 16);
    check("ovf_sready", S_READY, 0);
    check("ovf_oldest", M_DATA, 8'h01);

    // ---- drain in order ----
    S_VALID = 1'b0;
    M_READY = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check("drain_data", M_DATA, 32'(i));
      tick();
      check("drain_count", COUNT, 32'(16 - i));
      check("drain_sready", S_READY, 1);
    end
    check("drain_mvalid", M_VALID, 0);
    check("drain_mdata", M_DATA, 0);
    check("drain_af", ALMOST_FULL, 0);

    // ---- simultaneous push and pop at COUNT=3 ----
    M_READY = 1'b0;
    S_VALID = 1'b1;
    S_DATA = 8'h11; tick();
    S_DATA = 8'h22; tick();
    S_DATA = 8'h33; tick();
    check("pp_pre_count", COUNT, 3);
    S_DATA  = 8'h44;
    M_READY = 1'b1;
    check("pp_pop0", M_DATA, 8'h11); tick(); check("pp_count0", COUNT, 3);
    check("pp_pop1", M_DATA, 8'h22); tick(); check("pp_count1", COUNT, 3);
    check("pp_pop2", M_DATA, 8'h33); tick(); check("pp_count2", COUNT, 3);
    check("pp_pop3", M_DATA, 8'h44); tick(); check("pp_count3", COUNT, 3);
    S_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("pp_tail", M_DATA, 8'h44);
      tick();
    end
    check("pp_end_count", COUNT, 0);
    check("pp_end_mvalid", M_VALID, 0);

    // ---- pop while empty, then single write ----
    tick();
    check("epop_count", COUNT, 0);
    check("epop_mvalid", M_VALID, 0);
    M_READY = 1'b0;
    S_VALID = 1'b1;
    S_DATA  = 8'h5A;
    tick();
    check("single_mvalid", M_VALID, 1);
    check("single_mdata", M_DATA, 8'h5A);
    check("single_count", COUNT, 1);
    S_VALID = 1'b0;
    M_READY = 1'b1;
    tick();
    check("single_pop_count", COUNT, 0);
    check("single_pop_mvalid", M_VALID, 0);
    check("single_pop_mdata", M_DATA, 0);
    check("single_pop_sready", S_READY, 1);

    // ---- CLEAR with coincident push at COUNT=7 ----
    M_READY = 1'b0;
    S_VALID = 1'b1;
    for (int i = 0; i < 7; i++) begin
      S_DATA = 8'h70 + 8'(i);
      tick();
    end
    check("clr_pre_count", COUNT, 7);
    check("clr_pre_oldest", M_DATA, 8'h70);
    CLEAR  = 1'b1;
    S_DATA = 8'h77;
    tick();
    check("clr_count", COUNT, 0);
    check("clr_mvalid", M_VALID, 0);
    check("clr_sready", S_READY, 1);
    CLEAR   = 1'b0;
    S_VALID = 1'b0;
    tick();
    check("clr_not_stored", COUNT, 0);

    // ---- refill to 5, then asynchronous reset pulse mid-cycle ----
    S_VALID = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      S_DATA = 8'h80 + 8'(i);
      tick();
    end
    S_VALID = 1'b0;
    check("rf_count", COUNT, 5);
    check("rf_oldest", M_DATA, 8'h81);
    #3;
    RST = 1'b1;
    #1;
    check("arst_count", COUNT, 0);
    check("arst_mvalid", M_VALID, 0);
    check("arst_mdata", M_DATA, 0);
    check("arst_sready", S_READY, 0);
    #2;
    RST = 1'b0;
    #1;
    check("arst_rel_sready", S_READY, 0);
    tick();
    check("arst_edge_sready", S_READY, 1);
    check("arst_edge_count", COUNT, 0);
    S_VALID = 1'b1;
    S_DATA  = 8'h99;
    tick();
    S_VALID = 1'b0;
    check("post_rst_count", COUNT, 1);
    check("post_rst_data", M_DATA, 8'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/srl_fifo_ctrl.md
# srl_fifo_ctrl

Synchronous FIFO built on the team's 16-deep addressable shift-register storage: writes shift data in at tap 0, and a read pointer selects the oldest entry through the dynamic tap address. The block owns all sequencing: shift enable, tap address, occupancy and valid/ready handshakes. It sits between a streaming producer and consumer wherever a small, LUT-cheap elastic buffer is needed.

## Interface
Parameters:
- WIDTH, 8, data bits per entry; each bit uses one 16-deep shift column.
- AF_LEVEL, 12, ALMOST_FULL threshold in entries (1..16).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- CLEAR  in  1  synchronous flush; empties the FIFO on the next edge.
- S_DATA  in  WIDTH  write data.
- S_VALID  in  1  write request.
- S_READY  out  1  FIFO can accept a write this cycle.
- M_DATA  out  WIDTH  oldest entry; forced to 0 when M_VALID=0.
- M_VALID  out  1  FIFO holds at least one entry.
- M_READY  in  1  consumer takes M_DATA this cycle.
- COUNT  out  5  occupancy, 0..16.
- ALMOST_FULL  out  1  COUNT >= AF_LEVEL.

## Operation
- Storage: WIDTH columns × 16 entries, no reset. Shift enable CE = push. A push moves entry i to i+1 and loads S_DATA into entry 0. Entry 15 is discarded; this is unreachable, because a push at COUNT=16 is blocked.
- push = S_VALID & S_READY; pop = M_VALID & M_READY.
- Read tap A = COUNT-1 (4 bits), valid only when COUNT>0. M_DATA = storage[A] when M_VALID, else 0.
- FSM states: EMPTY (COUNT=0), ACTIVE (1..15), FULL (16).
  - EMPTY -> ACTIVE on push.
  - ACTIVE -> FULL on push without pop at COUNT=15.
  - ACTIVE -> EMPTY on pop without push at COUNT=1.
  - FULL -> ACTIVE on pop.
  - CLEAR from any state -> EMPTY.
- COUNT update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. The shift and the pop coincide, so tap A stays the same and now points at the next-oldest entry.
- Output flags:
  - S_READY = 1 in EMPTY and ACTIVE.
  - S_READY = 0 in FULL. There is no write pass-through when full, even if pop is asserted.
  - M_VALID = 1 in ACTIVE and FULL.
- Boundary conditions:
  - S_VALID in FULL: ignored, no shift, data not stored.
  - M_READY in EMPTY: ignored, COUNT stays 0.
  - CLEAR has priority over push and pop: COUNT -> 0 and no shift occurs that cycle. A push coinciding with CLEAR is dropped, even though S_READY was 1.
- Reset (asynchronous, any time, including mid-transfer):
  - COUNT=0, state EMPTY, M_VALID=0, M_DATA=0, ALMOST_FULL=0.
  - S_READY=0 while RST=1 and stays 0 until the first rising CLK edge after RST deasserts. A registered ready flag provides this.
  - Storage contents are not cleared and are never visible after reset.

## Timing
- All control outputs (S_READY, M_VALID, COUNT, ALMOST_FULL) come directly from registers. M_DATA is a mux of storage indexed by the registered COUNT, so it contains no combinational path from S_* or M_READY.
- Write-to-read latency: data pushed at edge k appears on M_DATA with M_VALID=1 immediately after edge k (1 cycle).
- Full back-to-back throughput: one push and one pop per cycle at any COUNT from 1 to 15.
- In FULL with M_READY=1: the pop at edge k gives S_READY=1 after k; a push can land at edge k+1.
- COUNT and ALMOST_FULL update in the same cycle as the state.

## Test plan
- Reset, then push 0x01..0x10 with M_READY=0:
  - COUNT steps 1..16 and the state ends in FULL, with S_READY=0 after the 16th edge.
  - ALMOST_FULL rises after the 12th push.
  - A 17th S_VALID with 0xAA leaves COUNT=16.
- Drain the full FIFO with M_READY=1: M_DATA reads 0x01..0x10 in order, 0xAA never appears, and M_VALID=0 and M_DATA=0 after 16 pops.
- Simultaneous push and pop:
  - Start with COUNT=3 (0x11, 0x22, 0x33).
  - Push 0x44 while popping for 4 cycles.
  - COUNT stays 3 and the pops return 0x11, 0x22, 0x33, 0x44.
- Empty-state pop and single write:
  - M_READY=1 at COUNT=0 leaves COUNT at 0.
  - Push 0x5A: M_VALID=1 and M_DATA=0x5A on the next cycle.
  - Pop it: the FIFO returns to EMPTY.
- CLEAR and reset mid-operation:
  - At COUNT=7, assert CLEAR together with push 0x77: COUNT=0 on the next edge and 0x77 is not stored.
  - Refill to 5, then pulse RST between clock edges: COUNT=0 and M_VALID=0 immediately, with S_READY=0 until the first edge after release.
